// File: rtl/saper_pkg.sv
// Shared definitions for the minesweeper number stage: level codes, board sizes
// and the neighbour-count FSM states.
package saper_pkg;

    localparam logic [1:0] LVL_INVALID = 2'd0;
    localparam logic [1:0] LVL_EASY    = 2'd1;
    localparam logic [1:0] LVL_MEDIUM  = 2'd2;
    localparam logic [1:0] LVL_HARD    = 2'd3;

    localparam int SIZE_EASY   = 8;
    localparam int SIZE_MEDIUM = 10;
    localparam int SIZE_HARD   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic [4:0] board_size(input logic [1:0] lvl);
        case (lvl)
            LVL_EASY:   return 5'(SIZE_EASY);
            LVL_MEDIUM: return 5'(SIZE_MEDIUM);
            LVL_HARD:   return 5'(SIZE_HARD);
            default:    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/neighbour_count.sv
// Combinational count of mines among the 8 neighbours of (row,col) on an NxN
// board, saturated to 3 bits. The field's own flag is never counted.
module neighbour_count (
    input  logic [15:0][15:0] map,
    input  logic [3:0]        row,
    input  logic [3:0]        col,
    input  logic [4:0]        n,
    output logic [2:0]        count
);

    logic [3:0] sum;

    always_comb begin
        logic [4:0] r;
        logic [4:0] c;
        sum = '0;
        r   = '0;
        c   = '0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                if (!(dr == 0 && dc == 0)) begin
                    // 5-bit wrap: -1 becomes 31 and 15+1 becomes 16, so a single
                    // compare against n rejects both board edges
                    r = {1'b0, row} + 5'(dr);
                    c = {1'b0, col} + 5'(dc);
                    if (r < n && c < n)
                        sum = sum + 4'(map[r[3:0]][c[3:0]]);
                end
            end
        end
        count = (sum > 4'd7) ? 3'd7 : sum[2:0];
    end

endmodule

// File: rtl/num_arr_calc.sv
// Neighbour-count calculator: latches level and mine map on start, clears the
// level's array, then scans it. NUM_CALC_ROWWISE_EN scans a full row per cycle.
module num_arr_calc
    import saper_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              level,
    input  logic [15:0][15:0]       mine_map,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [7:0][7:0][2:0]    num_arr_easy,
    output logic [9:0][9:0][2:0]    num_arr_medium,
    output logic [15:0][15:0][2:0]  num_arr_hard
);

    state_t                  state_reg;
    logic [1:0]              level_reg;
    logic [15:0][15:0]       map_reg;
    logic [3:0]              row_reg;
    logic [3:0]              col_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [7:0][7:0][2:0]    easy_reg;
    logic [9:0][9:0][2:0]    medium_reg;
    logic [15:0][15:0][2:0]  hard_reg;

    logic [4:0] n;
    logic [3:0] n_last;
    logic       scan_last;

    assign n      = board_size(level_reg);
    assign n_last = 4'(n - 5'd1);

`ifdef NUM_CALC_ROWWISE_EN
    logic [15:0][2:0] row_cnt;

    for (genvar gi = 0; gi < SIZE_HARD; gi++) begin : g_cell
        neighbour_count u_nc (
            .map   (map_reg),
            .row   (row_reg),
            .col   (4'(gi)),
            .n     (n),
            .count (row_cnt[gi])
        );
    end

    assign scan_last = (row_reg == n_last);
`else
    logic [2:0] cell_cnt;

    neighbour_count u_nc (
        .map   (map_reg),
        .row   (row_reg),
        .col   (col_reg),
        .n     (n),
        .count (cell_cnt)
    );

    assign scan_last = (row_reg == n_last) && (col_reg == n_last);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            level_reg  <= LVL_INVALID;
            map_reg    <= '0;
            row_reg    <= '0;
            col_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            easy_reg   <= '0;
            medium_reg <= '0;
            hard_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start && level != LVL_INVALID) begin
                        level_reg <= level;
                        map_reg   <= mine_map;
                        busy_reg  <= 1'b1;
                        state_reg <= CLEAR;
                    end
                end
                CLEAR: begin
                    case (level_reg)
                        LVL_EASY:   easy_reg   <= '0;
                        LVL_MEDIUM: medium_reg <= '0;
                        LVL_HARD:   hard_reg   <= '0;
                        default:    ;
                    endcase
                    row_reg   <= '0;
                    col_reg   <= '0;
                    state_reg <= SCAN;
                end
                SCAN: begin
`ifdef NUM_CALC_ROWWISE_EN
                    case (level_reg)
                        LVL_EASY:   easy_reg[row_reg[2:0]] <= row_cnt[7:0];
                        LVL_MEDIUM: medium_reg[row_reg]    <= row_cnt[9:0];
                        LVL_HARD:   hard_reg[row_reg]      <= row_cnt;
                        default:    ;
                    endcase
                    row_reg <= row_reg + 4'd1;
`else
                    case (level_reg)
                        LVL_EASY:   easy_reg[row_reg[2:0]][col_reg[2:0]] <= cell_cnt;
                        LVL_MEDIUM: medium_reg[row_reg][col_reg]         <= cell_cnt;
                        LVL_HARD:   hard_reg[row_reg][col_reg]           <= cell_cnt;
                        default:    ;
                    endcase
                    if (col_reg == n_last) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 4'd1;
                    end else begin
                        col_reg <= col_reg + 4'd1;
                    end
`endif
                    if (scan_last) begin
                        done_reg  <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_reg;
    assign done           = done_reg;
    assign num_arr_easy   = easy_reg;
    assign num_arr_medium = medium_reg;
    assign num_arr_hard   = hard_reg;

endmodule

// File: tb/tb_num_arr_calc.sv
// Self-checking bench for num_arr_calc: directed corner cases plus random maps
// checked against a plain neighbour-counting model.
module tb_num_arr_calc;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [1:0]              level = 2'd0;
    logic [15:0][15:0]       mine_map = '0;
    logic                    start = 1'b0;
    logic                    busy;
    logic                    done;
    logic [7:0][7:0][2:0]    num_arr_easy;
    logic [9:0][9:0][2:0]    num_arr_medium;
    logic [15:0][15:0][2:0]  num_arr_hard;

    int tests = 0;
    int fails = 0;
    int exp_e [8][8];
    int exp_m [10][10];
    int exp_h [16][16];

    num_arr_calc dut (
        .clk            (clk),
        .rst            (rst),
        .level          (level),
        .mine_map       (mine_map),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .num_arr_easy   (num_arr_easy),
        .num_arr_medium (num_arr_medium),
        .num_arr_hard   (num_arr_hard)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int size_of(input int lvl);
        return (lvl == 1) ? 8 : (lvl == 2) ? 10 : 16;
    endfunction

    function automatic int exp_latency(input int lvl);
`ifdef NUM_CALC_ROWWISE_EN
        return size_of(lvl) + 2;
`else
        return size_of(lvl) * size_of(lvl) + 2;
`endif
    endfunction

    function automatic int ref_cnt(input logic [15:0][15:0] m, input int n, input int r, input int c);
        int s = 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < n && c + dc >= 0 && c + dc < n)
                    if (m[r + dr][c + dc]) s++;
        return (s > 7) ? 7 : s;
    endfunction

    task automatic model_apply(input int lvl, input logic [15:0][15:0] m);
        int n = size_of(lvl);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                case (lvl)
                    1: exp_e[r][c] = ref_cnt(m, n, r, c);
                    2: exp_m[r][c] = ref_cnt(m, n, r, c);
                    default: exp_h[r][c] = ref_cnt(m, n, r, c);
                endcase
    endtask

    task automatic model_reset();
        foreach (exp_e[r, c]) exp_e[r][c] = 0;
        foreach (exp_m[r, c]) exp_m[r][c] = 0;
        foreach (exp_h[r, c]) exp_h[r][c] = 0;
    endtask

    function automatic int mism(input int lvl);
        int k = 0;
        int n = size_of(lvl);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                case (lvl)
                    1: if (int'(num_arr_easy[r][c]) != exp_e[r][c]) k++;
                    2: if (int'(num_arr_medium[r][c]) != exp_m[r][c]) k++;
                    default: if (int'(num_arr_hard[r][c]) != exp_h[r][c]) k++;
                endcase
        return k;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_easy_mismatches"}, mism(1), 0);
        check({tag, "_medium_mismatches"}, mism(2), 0);
        check({tag, "_hard_mismatches"}, mism(3), 0);
    endtask

    function automatic logic [15:0][15:0] rand_map(input bit dense);
        logic [15:0][15:0] m;
        for (int r = 0; r < 16; r++)
            m[r] = dense ? (16'($urandom()) | 16'($urandom())) : (16'($urandom()) & 16'($urandom()));
        return m;
    endfunction

    // Runs one computation; interrupt_at>0 injects a conflicting start at that cycle.
    task automatic run_calc(input string tag, input logic [1:0] lvl, input logic [15:0][15:0] m,
                            input int interrupt_at);
        int lat;
        @(negedge clk);
        level = lvl; mine_map = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        check({tag, "_busy_after_start"}, int'(busy), 1);
        while (done !== 1'b1 && lat < 600) begin
            if (lat == interrupt_at) begin
                start = 1'b1; level = 2'd1; mine_map = ~m;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, "_latency"}, lat, exp_latency(int'(lvl)));
        model_apply(int'(lvl), m);
        @(posedge clk); #1;
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_busy_low_after"}, int'(busy), 0);
        compare_all(tag);
        $display("[TB] %s level=%0d latency=%0d", tag, lvl, lat);
    endtask

    initial begin
        logic [15:0][15:0] m;
        int dones;
        model_reset();

        // reset state
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        compare_all("reset");
        @(negedge clk) rst = 1'b1;

        // level 0 start is ignored
        @(negedge clk);
        level = 2'd0; mine_map = rand_map(1'b1); start = 1'b1;
        @(negedge clk) start = 1'b0;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) dones++;
        end
        check("level0_no_activity", dones, 0);
        $display("[TB] level0 start ignored check");

        // easy, single mine at (3,3)
        m = '0; m[3][3] = 1'b1;
        run_calc("easy_single", 2'd1, m, 0);
        check("easy_2_2", int'(num_arr_easy[2][2]), 1);
        check("easy_4_4", int'(num_arr_easy[4][4]), 1);
        check("easy_3_3_self", int'(num_arr_easy[3][3]), 0);
        check("easy_5_5", int'(num_arr_easy[5][5]), 0);

        // hard, corner cluster
        m = '0; m[0][1] = 1'b1; m[1][0] = 1'b1; m[1][1] = 1'b1;
        run_calc("hard_corner", 2'd3, m, 0);
        check("hard_0_0", int'(num_arr_hard[0][0]), 3);
        check("hard_15_15", int'(num_arr_hard[15][15]), 0);

        // medium, saturation at (5,5); easy array must stay as before
        m = '0;
        for (int r = 4; r <= 6; r++)
            for (int c = 4; c <= 6; c++)
                if (r != 5 || c != 5) m[r][c] = 1'b1;
        run_calc("medium_sat", 2'd2, m, 0);
        check("medium_5_5_sat", int'(num_arr_medium[5][5]), 7);
        check("easy_kept_2_2", int'(num_arr_easy[2][2]), 1);

        // second start during scan is ignored
        m = rand_map(1'b0);
        run_calc("restart_ignored", 2'd3, m, 20);
        dones = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (done === 1'b1) dones++;
        end
        check("restart_single_done", dones, 0);
        compare_all("restart_after");

        // reset at cycle 30 of a hard scan
        @(negedge clk);
        level = 2'd3; mine_map = rand_map(1'b1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        model_reset();
        check("midreset_busy", int'(busy), 0);
        check("midreset_done", int'(done), 0);
        compare_all("midreset");
        $display("[TB] reset asserted mid-scan");
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_resume_busy", int'(busy), 0);
        run_calc("after_reset", 2'd1, rand_map(1'b0), 0);

        // random maps over all levels (bits outside NxN are random too)
        for (int i = 0; i < 6; i++)
            run_calc($sformatf("random%0d", i), 2'($urandom_range(1, 3)), rand_map(i[0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
